// File: rtl/panel_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : panel_scan_controller
// Description : Row-multiplexed LED panel scan engine with binary-code-modulated
//               bit planes. Optional all-ones test pattern under macro
//               PANEL_TEST_PATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module panel_scan_controller #(
    parameter int NUM_CHANNELS = 12,
    parameter int NUM_ROWS     = 16,
    parameter int NUM_COLS     = 48,
    parameter int BIT_DEPTH    = 4,
    parameter int CLK_DIV      = 2,
    parameter int BASE_TIME    = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           enable,
    input  logic                                           test_mode,
    output logic                                           rd_en,
    output logic [$clog2(NUM_ROWS)-1:0]                    rd_row,
    output logic [((NUM_COLS > 1) ? $clog2(NUM_COLS) : 1)-1:0] rd_col,
    input  logic [NUM_CHANNELS*BIT_DEPTH-1:0]              rd_data,
    output logic                                           serial_clk,
    output logic [NUM_CHANNELS-1:0]                        serial_data_out,
    output logic                                           latch_enable,
    output logic                                           output_enable_n,
    output logic [NUM_ROWS-1:0]                            row_select_n,
    output logic                                           frame_start
);

    localparam int c_ROW_W   = $clog2(NUM_ROWS);
    localparam int c_COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int c_PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam int c_PH_W    = $clog2(2 * CLK_DIV);
    localparam int c_DISP_W  = $clog2(BASE_TIME << (BIT_DEPTH - 1)) + 1;

    localparam logic [c_ROW_W-1:0]   c_ROW_LAST   = c_ROW_W'(NUM_ROWS - 1);
    localparam logic [c_COL_W-1:0]   c_COL_LAST   = c_COL_W'(NUM_COLS - 1);
    localparam logic [c_PLANE_W-1:0] c_PLANE_LAST = c_PLANE_W'(BIT_DEPTH - 1);
    localparam logic [c_PH_W-1:0]    c_PH_LAST    = c_PH_W'(2 * CLK_DIV - 1);
    localparam logic [c_PH_W-1:0]    c_PH_HIGH    = c_PH_W'(CLK_DIV);
    localparam logic [c_PH_W-1:0]    c_PH_DATA    = c_PH_W'(1);
    localparam logic [c_DISP_W-1:0]  c_BASE       = c_DISP_W'(BASE_TIME);
    localparam logic [NUM_ROWS-1:0]  c_ROW_ONE    = {{(NUM_ROWS-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SHIFT   = 2'd1;
    localparam logic [1:0] c_ST_LATCH   = 2'd2;
    localparam logic [1:0] c_ST_DISPLAY = 2'd3;

    logic [1:0]           r_state,    w_state_nx;
    logic [c_ROW_W-1:0]   r_row,      w_row_nx;
    logic [c_PLANE_W-1:0] r_plane,    w_plane_nx;
    logic [c_COL_W-1:0]   r_col,      w_col_nx;
    logic [c_PH_W-1:0]    r_phase,    w_phase_nx;
    logic                 r_lph,      w_lph_nx;
    logic [c_DISP_W-1:0]  r_disp_cnt, w_disp_nx;

    logic [c_DISP_W-1:0]     w_disp_len;
    logic                    w_disp_last;
    logic                    w_shift_entry;
    logic                    w_rd_block;
    logic [NUM_CHANNELS-1:0] w_plane_bits;
    logic [NUM_CHANNELS-1:0] w_shift_bits;

    assign w_disp_len  = c_BASE << r_plane;
    assign w_disp_last = (r_disp_cnt == (w_disp_len - c_DISP_W'(1)));

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_plane_nx = r_plane;
        w_col_nx   = r_col;
        w_phase_nx = r_phase;
        w_lph_nx   = r_lph;
        w_disp_nx  = r_disp_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    w_state_nx = c_ST_SHIFT;
                    w_row_nx   = '0;
                    w_plane_nx = '0;
                    w_col_nx   = '0;
                    w_phase_nx = '0;
                end
            end
            c_ST_SHIFT: begin
                if (r_phase == c_PH_LAST) begin
                    w_phase_nx = '0;
                    if (r_col == c_COL_LAST) begin
                        w_col_nx   = '0;
                        w_lph_nx   = 1'b0;
                        w_state_nx = c_ST_LATCH;
                    end else begin
                        w_col_nx = r_col + c_COL_W'(1);
                    end
                end else begin
                    w_phase_nx = r_phase + c_PH_W'(1);
                end
            end
            c_ST_LATCH: begin
                if (!r_lph) begin
                    w_lph_nx = 1'b1;
                end else begin
                    w_lph_nx   = 1'b0;
                    w_state_nx = c_ST_DISPLAY;
                    w_disp_nx  = '0;
                end
            end
            c_ST_DISPLAY: begin
                if (w_disp_last) begin
                    w_disp_nx = '0;
                    if (r_plane == c_PLANE_LAST) begin
                        w_plane_nx = '0;
                        w_row_nx   = (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_W'(1);
                    end else begin
                        w_plane_nx = r_plane + c_PLANE_W'(1);
                    end
                    // Enable is only honoured here: a plane already shifted is always shown.
                    if (enable) begin
                        w_state_nx = c_ST_SHIFT;
                        w_col_nx   = '0;
                        w_phase_nx = '0;
                    end else begin
                        w_state_nx = c_ST_IDLE;
                        w_row_nx   = '0;
                        w_plane_nx = '0;
                    end
                end else begin
                    w_disp_nx = r_disp_cnt + c_DISP_W'(1);
                end
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    assign w_shift_entry = (w_state_nx == c_ST_SHIFT) && (r_state != c_ST_SHIFT);

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
            logic [BIT_DEPTH-1:0] w_lane;
            assign w_lane          = rd_data[c*BIT_DEPTH +: BIT_DEPTH];
            assign w_plane_bits[c] = w_lane[r_plane];
        end
    endgenerate

`ifdef PANEL_TEST_PATTERN_EN
    // Pattern selection is frozen for a whole plane so a plane is never mixed.
    logic r_test;
    logic w_test_nx;
    assign w_test_nx    = w_shift_entry ? test_mode : r_test;
    assign w_rd_block   = w_test_nx;
    assign w_shift_bits = r_test ? {NUM_CHANNELS{1'b1}} : w_plane_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_test <= 1'b0;
        end else begin
            r_test <= w_test_nx;
        end
    end
`else
    logic w_unused_test;
    assign w_unused_test = test_mode;
    assign w_rd_block    = 1'b0;
    assign w_shift_bits  = w_plane_bits;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_row      <= '0;
            r_plane    <= '0;
            r_col      <= '0;
            r_phase    <= '0;
            r_lph      <= 1'b0;
            r_disp_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_row      <= w_row_nx;
            r_plane    <= w_plane_nx;
            r_col      <= w_col_nx;
            r_phase    <= w_phase_nx;
            r_lph      <= w_lph_nx;
            r_disp_cnt <= w_disp_nx;
        end
    end

    // Outputs are registered from next-state values so each one lines up with its state cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en           <= 1'b0;
            rd_row          <= '0;
            rd_col          <= '0;
            serial_clk      <= 1'b0;
            serial_data_out <= '0;
            latch_enable    <= 1'b0;
            output_enable_n <= 1'b1;
            row_select_n    <= '1;
            frame_start     <= 1'b0;
        end else begin
            rd_en        <= (w_state_nx == c_ST_SHIFT) && (w_phase_nx == '0) && !w_rd_block;
            serial_clk   <= (w_state_nx == c_ST_SHIFT) && (w_phase_nx >= c_PH_HIGH);
            latch_enable <= (w_state_nx == c_ST_LATCH) && w_lph_nx;
            output_enable_n <= (w_state_nx != c_ST_DISPLAY);
            frame_start  <= w_shift_entry && (w_row_nx == '0) && (w_plane_nx == '0);
            if ((w_state_nx == c_ST_SHIFT) && (w_phase_nx == '0)) begin
                rd_row <= w_row_nx;
                rd_col <= w_col_nx;
            end
            // rd_data for this column is valid during phase cycle 1.
            if ((r_state == c_ST_SHIFT) && (r_phase == c_PH_DATA)) begin
                serial_data_out <= w_shift_bits;
            end
            if (w_state_nx == c_ST_IDLE) begin
                row_select_n <= '1;
            end else if ((w_state_nx == c_ST_LATCH) && !w_lph_nx) begin
                row_select_n <= ~(c_ROW_ONE << w_row_nx);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_panel_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_panel_scan_controller
// Description : Self-checking bench for panel_scan_controller using a frame
//               buffer reference and randomized pixel data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_scan_controller;

    localparam int NC   = 2;
    localparam int NR   = 4;
    localparam int NCOL = 8;
    localparam int BD   = 2;
    localparam int CD   = 2;
    localparam int BT   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       test_mode;
    logic       rd_en;
    logic [1:0] rd_row;
    logic [2:0] rd_col;
    logic [3:0] rd_data;
    logic       serial_clk;
    logic [1:0] serial_data_out;
    logic       latch_enable;
    logic       output_enable_n;
    logic [3:0] row_select_n;
    logic       frame_start;

    logic [3:0] fb [NR][NCOL];
    bit         tm_expect;
    int         n_checks;
    int         n_fail;
    int         rd_count;

    panel_scan_controller #(
        .NUM_CHANNELS(NC), .NUM_ROWS(NR), .NUM_COLS(NCOL),
        .BIT_DEPTH(BD), .CLK_DIV(CD), .BASE_TIME(BT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .test_mode(test_mode),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .serial_clk(serial_clk), .serial_data_out(serial_data_out),
        .latch_enable(latch_enable), .output_enable_n(output_enable_n),
        .row_select_n(row_select_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous pixel store: data appears the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en === 1'b1) rd_data <= fb[rd_row][rd_col];
        else                rd_data <= 4'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en === 1'b1) rd_count++;
        n_checks++;
        assert (($countones(~row_select_n) <= 1) &&
                (output_enable_n || ($countones(~row_select_n) == 1))) else begin
            n_fail++;
            $error("FAIL row_select_onehot: observed rsn=%b oe_n=%b expected <=1 low, 1 low while lit",
                   row_select_n, output_enable_n);
        end
    end

    function automatic logic [1:0] exp_bits(input int r, input int k, input int p);
        logic [3:0] w;
        if (tm_expect) return 2'b11;
        w = fb[r][k];
        return {w[2+p], w[p]};
    endfunction

    task automatic fill_const();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NCOL; k++) fb[r][k] = 4'b1001;
    endtask

    task automatic fill_random();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NCOL; k++) fb[r][k] = 4'($urandom);
    endtask

    // Follows one plane from shift through display; returns on the first blanked sample after it.
    task automatic run_plane(input int r, input int p, input bit drop,
                             output logic fs_exit, output logic [3:0] rsn_exit);
        logic       prev;
        int         rises;
        int         low;
        bit         seen;
        bit         rs_ok;
        logic [1:0] cap [NCOL];
        logic [3:0] exp_rs;
        exp_rs = ~(4'b0001 << r);
        prev   = serial_clk;
        rises  = 0;
        seen   = 0;
        for (int k = 0; k < NCOL; k++) cap[k] = 2'bxx;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (serial_clk && !prev) begin
                if (rises < NCOL) cap[rises] = serial_data_out;
                rises++;
                if (drop && rises == 3) enable = 1'b0;
            end
            prev = serial_clk;
            if (latch_enable) seen = 1;
        end
        check($sformatf("latch_seen_r%0dp%0d", r, p), seen, 1);
        check($sformatf("sclk_rises_r%0dp%0d", r, p), rises, NCOL);
        check($sformatf("latch_rsn_r%0dp%0d", r, p), row_select_n, exp_rs);
        check($sformatf("latch_oe_n_r%0dp%0d", r, p), output_enable_n, 1);
        for (int k = 0; k < NCOL; k++)
            check($sformatf("data_r%0dp%0dc%0d", r, p, k), cap[k], exp_bits(r, k, p));
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!output_enable_n) seen = 1;
        end
        check($sformatf("display_start_r%0dp%0d", r, p), seen, 1);
        low   = 0;
        rs_ok = 1;
        while (!output_enable_n && low < 100) begin
            if (row_select_n !== exp_rs) rs_ok = 0;
            low++;
            @(negedge clk);
        end
        check($sformatf("display_len_r%0dp%0d", r, p), low, BT << p);
        check($sformatf("display_rsn_r%0dp%0d", r, p), rs_ok, 1);
        fs_exit  = frame_start;
        rsn_exit = row_select_n;
    endtask

    initial begin
        logic       fs;
        logic [3:0] rsn;
        bit         found;
        bit         quiet;
        int         snap;
        logic [1:0] last_bits;

        n_checks  = 0;
        n_fail    = 0;
        rd_count  = 0;
        tm_expect = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        test_mode = 1'b0;
        fill_const();

        repeat (3) @(negedge clk);
        check("rst_oe_n", output_enable_n, 1);
        check("rst_rsn", row_select_n, 4'hF);
        check("rst_sclk", serial_clk, 0);
        check("rst_latch", latch_enable, 0);
        check("rst_sdo", serial_data_out, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_row", rd_row, 0);
        check("rst_rd_col", rd_col, 0);
        check("rst_fs", frame_start, 0);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_oe_n", output_enable_n, 1);
        check("idle_rd_en", rd_en, 0);
        check("idle_sclk", serial_clk, 0);

        // Constant pixel word 4'b10_01, one full frame plus wrap.
        enable = 1'b1;
        @(negedge clk);
        check("start_fs", frame_start, 1);
        check("start_rd_en", rd_en, 1);
        check("start_rd_row", rd_row, 0);
        check("start_rd_col", rd_col, 0);
        for (int r = 0; r < NR; r++) begin
            for (int p = 0; p < BD; p++) begin
                run_plane(r, p, 1'b0, fs, rsn);
                check($sformatf("fs_after_r%0dp%0d", r, p), fs, (r == NR-1) && (p == BD-1));
            end
        end
        fill_random();

        // Random frame, enable dropped during row 2 plane 0 shift.
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < BD; p++) begin
                run_plane(r, p, 1'b0, fs, rsn);
                check($sformatf("fsB_after_r%0dp%0d", r, p), fs, 0);
            end
        end
        run_plane(2, 0, 1'b1, fs, rsn);
        check("drop_rsn", rsn, 4'hF);
        check("drop_fs", fs, 0);
        last_bits = exp_bits(2, NCOL-1, 0);
        quiet = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (serial_clk || !output_enable_n || rd_en || latch_enable) quiet = 0;
        end
        check("drop_idle_quiet", quiet, 1);
        check("drop_sdo_hold", serial_data_out, last_bits);

        // Asynchronous reset during display.
        enable = 1'b1;
        @(negedge clk);
        check("restart_fs", frame_start, 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (!output_enable_n) found = 1;
        end
        check("disp_reached", found, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_disp_oe_n", output_enable_n, 1);
        check("arst_disp_rsn", row_select_n, 4'hF);
        check("arst_disp_latch", latch_enable, 0);
        check("arst_disp_sdo", serial_data_out, 0);
        check("arst_disp_fs", frame_start, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_fs", frame_start, 1);
        run_plane(0, 0, 1'b0, fs, rsn);
        check("post_rst_fs_after_r0p0", fs, 0);

        // Asynchronous reset during shift.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (serial_clk) found = 1;
        end
        check("shift_reached", found, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_shift_sclk", serial_clk, 0);
        check("arst_shift_oe_n", output_enable_n, 1);
        check("arst_shift_sdo", serial_data_out, 0);
        check("arst_shift_rd_en", rd_en, 0);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clk);
        check("idle2_sclk", serial_clk, 0);
        check("idle2_oe_n", output_enable_n, 1);

        // test_mode frame: all-ones only when the pattern feature is built in.
        fill_random();
        test_mode = 1'b1;
`ifdef PANEL_TEST_PATTERN_EN
        tm_expect = 1;
`else
        tm_expect = 0;
`endif
        snap   = rd_count;
        enable = 1'b1;
        @(negedge clk);
        check("tm_start_fs", frame_start, 1);
        for (int r = 0; r < NR; r++) begin
            for (int p = 0; p < BD; p++) begin
                run_plane(r, p, (r == NR-1) && (p == BD-1), fs, rsn);
                check($sformatf("tm_fs_after_r%0dp%0d", r, p), fs, 0);
            end
        end
        check("tm_end_rsn", rsn, 4'hF);
        check("tm_rd_count", rd_count - snap, tm_expect ? 0 : NR * BD * NCOL);
        test_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/panel_scan_controller.md
PANEL_SCAN_CONTROLLER -- requirements
Module: panel_scan_controller

Interface
REQ-001 Parameter NUM_CHANNELS, default 12: number of parallel serial data lanes.
REQ-002 Parameter NUM_ROWS, default 16: number of multiplexed rows (>=2).
REQ-003 Parameter NUM_COLS, default 48: shift-register bits per lane per row (>=1).
REQ-004 Parameter BIT_DEPTH, default 4: brightness bits per pixel, binary-code-modulated (>=1).
REQ-005 Parameter CLK_DIV, default 2: clk cycles per serial_clk half-period (>=2).
REQ-006 Parameter BASE_TIME, default 8: display cycles for bit plane 0 (>=1).
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  run scanning; low idles the panel blanked.
REQ-010 test_mode  input  1  force all-on data (effective only per REQ-029).
REQ-011 rd_en  output  1  pixel read strobe, one cycle per column.
REQ-012 rd_row  output  clog2(NUM_ROWS)  row address of read.
REQ-013 rd_col  output  clog2(NUM_COLS)  column address of read.
REQ-014 rd_data  input  NUM_CHANNELS*BIT_DEPTH  pixel values, lane c in bits [c*BIT_DEPTH +: BIT_DEPTH], valid exactly one cycle after rd_en.
REQ-015 serial_clk  output  1  shift clock to panel drivers.
REQ-016 serial_data_out  output  NUM_CHANNELS  one data bit per lane.
REQ-017 latch_enable  output  1  transfer shift registers to driver outputs.
REQ-018 output_enable_n  output  1  active-low driver enable.
REQ-019 row_select_n  output  NUM_ROWS  active-low one-hot row drive.
REQ-020 frame_start  output  1  one-cycle pulse at start of row 0 plane 0 shift.

Function
REQ-021 States: IDLE, SHIFT, LATCH, DISPLAY; all outputs registered.
- IDLE: output_enable_n=1, row_select_n all ones; enable=1 -> SHIFT with row=0, plane=0, col=0, frame_start pulse.
- SHIFT: per column, 2*CLK_DIV cycles: rd_en=1 with rd_row/rd_col on phase cycle 0; serial_clk low for cycles 0..CLK_DIV-1, high for CLK_DIV..2*CLK_DIV-1; serial_data_out[c] = bit <plane> of lane c rd_data, updated on phase cycle 1 and held through the high half; after column NUM_COLS-1 -> LATCH.
- LATCH: output_enable_n=1 one cycle, then latch_enable=1 one cycle; row_select_n switches to current row during this blank; -> DISPLAY.
- DISPLAY: output_enable_n=0 for exactly BASE_TIME<<plane cycles, row_select_n[row]=0 only; then output_enable_n=1 and advance plane; plane wrap BIT_DEPTH-1->0 advances row; row wrap NUM_ROWS-1->0 pulses frame_start at next SHIFT entry.
REQ-022 Rows advance only while output_enable_n=1; at most one row_select_n bit low, ever.
REQ-023 enable sampled only in IDLE and at DISPLAY end; enable=0 mid-SHIFT completes that plane's latch and display, then IDLE.
REQ-024 Display counter width clog2(BASE_TIME<<(BIT_DEPTH-1))+1 bits; no overflow at maximum plane.
REQ-025 serial_clk idles low outside SHIFT; serial_data_out holds last value outside SHIFT.

Reset
REQ-026 Reset asserted: state IDLE, serial_clk=0, latch_enable=0, output_enable_n=1, serial_data_out=0, row_select_n all ones, rd_en=0, rd_row=0, rd_col=0, frame_start=0, counters zero.
REQ-027 Reset asserted mid-SHIFT or DISPLAY blanks immediately (asynchronous); after release scan restarts at row 0 plane 0.
REQ-028 First rising edge after release evaluates IDLE transition normally.

Configuration
REQ-029 Macro PANEL_TEST_PATTERN_EN defined: test_mode=1 holds rd_en=0 and substitutes all-ones pixel data at plane boundaries; undefined: test_mode ignored, no substitution logic synthesised.

Verification (NUM_CHANNELS=2, NUM_ROWS=4, NUM_COLS=8, BIT_DEPTH=2, CLK_DIV=2, BASE_TIME=4)
REQ-030 Reset pulse mid-run -> output_enable_n=1, row_select_n=4'b1111 within same cycle; restart with frame_start after enable.
REQ-031 rd_data=4'b10_01 constant, enable=1 -> plane 0 shifts lane0=1, lane1=0; plane 1 shifts lane0=0, lane1=1; 8 serial_clk rising edges per plane.
REQ-032 Per row -> output_enable_n low 4 cycles (plane 0) then 8 cycles (plane 1); row_select_n sequence 1110,1101,1011,0111,1110.
REQ-033 enable dropped during row 2 plane 0 SHIFT -> latch and 4-cycle display complete, then IDLE, row_select_n=1111.
REQ-034 PANEL_TEST_PATTERN_EN defined, test_mode=1 -> rd_en never asserts, serial_data_out=2'b11 on every shift; undefined -> rd_data drives output.
